// File: rtl/instr_pipeline_buffer.sv
// Inter-stage instruction FIFO with valid/ready on both sides. Head entries whose epoch
// differs from the live branch epoch are presented as NOP and counted when popped.
module instr_pipeline_buffer #(
    parameter int unsigned              INSTR_W  = 32,
    parameter int unsigned              EPOCH_W  = 2,
    parameter int unsigned              DEPTH    = 2,
    parameter logic [INSTR_W-1:0]       NOP      = 32'hE320F000,
    parameter int unsigned              SQ_CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [INSTR_W-1:0]          in_instr,
    input  logic [EPOCH_W-1:0]          in_epoch,
    input  logic [EPOCH_W-1:0]          cur_epoch,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INSTR_W-1:0]          out_instr,
    output logic [EPOCH_W-1:0]          out_epoch,
    output logic                        out_squashed,
    output logic [$clog2(DEPTH):0]      count,
    output logic [SQ_CNT_W-1:0]         squash_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]    FULL   = CNT_W'(DEPTH);
    localparam logic [SQ_CNT_W-1:0] SQ_MAX = {SQ_CNT_W{1'b1}};

    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [EPOCH_W-1:0] epoch_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [SQ_CNT_W-1:0] sq_cnt_q, sq_cnt_d;

    logic               push, pop;
    logic [INSTR_W-1:0] head_instr;
    logic [EPOCH_W-1:0] head_epoch;

    assign head_instr = instr_q[rd_ptr_q];
    assign head_epoch = epoch_q[rd_ptr_q];

    always_comb begin
        in_ready     = (count_q != FULL) & ~flush;
        out_valid    = (count_q != '0);
        out_squashed = out_valid & (head_epoch != cur_epoch);
        out_instr    = (out_valid & ~out_squashed) ? head_instr : NOP;
        out_epoch    = out_valid ? head_epoch : '0;
        count        = count_q;
        squash_cnt   = sq_cnt_q;
        push         = in_valid & in_ready;
        pop          = out_valid & out_ready;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        sq_cnt_d = sq_cnt_q;
        if (flush) begin
            // A pop coinciding with flush is discarded and never reaches squash_cnt.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            if (pop && out_squashed && (sq_cnt_q != SQ_MAX)) sq_cnt_d = sq_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sq_cnt_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sq_cnt_q <= sq_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_q[i] <= NOP;
                epoch_q[i] <= '0;
            end
        end else if (push) begin
            instr_q[wr_ptr_q] <= in_instr;
            epoch_q[wr_ptr_q] <= in_epoch;
        end
    end

endmodule

// File: tb/tb_instr_pipeline_buffer.sv
// Directed bench for instr_pipeline_buffer (DEPTH=2, SQ_CNT_W=2 so saturation is reachable).
module tb_instr_pipeline_buffer;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned EPOCH_W  = 2;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'hE320F000;
    localparam int unsigned SQ_CNT_W = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid, in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [EPOCH_W-1:0] in_epoch, cur_epoch;
    logic               flush;
    logic               out_valid, out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [EPOCH_W-1:0] out_epoch;
    logic               out_squashed;
    logic [1:0]         count;
    logic [SQ_CNT_W-1:0] squash_cnt;

    int total_cnt = 0;
    int pass_cnt  = 0;

    instr_pipeline_buffer #(
        .INSTR_W  (INSTR_W),
        .EPOCH_W  (EPOCH_W),
        .DEPTH    (DEPTH),
        .NOP      (NOP),
        .SQ_CNT_W (SQ_CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_epoch     (in_epoch),
        .cur_epoch    (cur_epoch),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_epoch    (out_epoch),
        .out_squashed (out_squashed),
        .count        (count),
        .squash_cnt   (squash_cnt)
    );

    always #5 clk = ~clk;

    // Overflow/underflow must never happen.
    always @(posedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready && count == 2'(DEPTH)) begin
                total_cnt++;
                $display("FAIL overflow: push with count=%0d", count);
            end
            if (out_ready && out_valid && count == 2'd0) begin
                total_cnt++;
                $display("FAIL underflow: pop with count=%0d", count);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] instr, input logic [1:0] epoch);
        in_valid = 1'b1;
        in_instr = instr;
        in_epoch = epoch;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total_cnt++;
        if (out_valid !== 1'b0 || out_instr !== NOP || out_epoch !== 2'd0 ||
            out_squashed !== 1'b0 || in_ready !== 1'b1 || count !== 2'd0 ||
            squash_cnt !== 2'd0)
            $display("FAIL reset_state: valid=%b instr=%h epoch=%0d sq=%b rdy=%b cnt=%0d sqc=%0d",
                     out_valid, out_instr, out_epoch, out_squashed, in_ready, count, squash_cnt);
        else pass_cnt++;
    endtask

    task automatic test_fill_drain();
        cur_epoch = 2'd0;
        push_one(32'h11111111, 2'd0);
        total_cnt++;
        if (count !== 2'd1 || out_valid !== 1'b1 || out_instr !== 32'h11111111)
            $display("FAIL fill_one: cnt=%0d valid=%b instr=%h want 1 1 11111111",
                     count, out_valid, out_instr);
        else pass_cnt++;
        push_one(32'h22222222, 2'd0);
        total_cnt++;
        if (count !== 2'd2 || in_ready !== 1'b0 || out_instr !== 32'h11111111)
            $display("FAIL fill_full: cnt=%0d rdy=%b instr=%h want 2 0 11111111",
                     count, in_ready, out_instr);
        else pass_cnt++;
        pop_one();
        total_cnt++;
        if (count !== 2'd1 || out_instr !== 32'h22222222 || out_squashed !== 1'b0)
            $display("FAIL drain_first: cnt=%0d instr=%h sq=%b want 1 22222222 0",
                     count, out_instr, out_squashed);
        else pass_cnt++;
        pop_one();
        total_cnt++;
        if (count !== 2'd0 || out_valid !== 1'b0 || out_instr !== NOP)
            $display("FAIL drain_empty: cnt=%0d valid=%b instr=%h want 0 0 %h",
                     count, out_valid, out_instr, NOP);
        else pass_cnt++;
    endtask

    task automatic test_squash();
        cur_epoch = 2'd0;
        push_one(32'hE0811002, 2'd1);
        total_cnt++;
        if (out_instr !== NOP || out_squashed !== 1'b1 || out_epoch !== 2'd1 || out_valid !== 1'b1)
            $display("FAIL squash_head: instr=%h sq=%b ep=%0d valid=%b want %h 1 1 1",
                     out_instr, out_squashed, out_epoch, out_valid, NOP);
        else pass_cnt++;
        cur_epoch = 2'd1;
        #1;
        total_cnt++;
        if (out_instr !== 32'hE0811002 || out_squashed !== 1'b0)
            $display("FAIL epoch_match: instr=%h sq=%b want e0811002 0", out_instr, out_squashed);
        else pass_cnt++;
        cur_epoch = 2'd0;
        #1;
        pop_one();
        total_cnt++;
        if (squash_cnt !== 2'd1 || count !== 2'd0)
            $display("FAIL squash_count: sqc=%0d cnt=%0d want 1 0", squash_cnt, count);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_head;
        push_one(32'hC0C0C0C0, 2'd0);
        exp_head = 32'hC0C0C0C0;
        in_valid  = 1'b1;
        in_epoch  = 2'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_instr = 32'h30000000 + i;
            #1;
            total_cnt++;
            if (out_instr !== exp_head)
                $display("FAIL b2b_head[%0d]: instr=%h want %h", i, out_instr, exp_head);
            else pass_cnt++;
            step();
            exp_head = 32'h30000000 + i;
            total_cnt++;
            if (count !== 2'd1)
                $display("FAIL b2b_count[%0d]: cnt=%0d want 1", i, count);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        total_cnt++;
        if (out_instr !== 32'h30000005)
            $display("FAIL b2b_last: instr=%h want 30000005", out_instr);
        else pass_cnt++;
        step();
        out_ready = 1'b0;
        total_cnt++;
        if (count !== 2'd0 || squash_cnt !== 2'd1)
            $display("FAIL b2b_end: cnt=%0d sqc=%0d want 0 1", count, squash_cnt);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        push_one(32'hF1F1F1F1, 2'd0);
        push_one(32'hF2F2F2F2, 2'd0);
        in_valid  = 1'b1;
        in_instr  = 32'hDEADBEEF;
        in_epoch  = 2'd0;
        out_ready = 1'b1;
        flush     = 1'b1;
        cur_epoch = 2'd1;  // head squashed: the discarded pop must not be counted
        #1;
        total_cnt++;
        if (in_ready !== 1'b0)
            $display("FAIL flush_ready: rdy=%b want 0", in_ready);
        else pass_cnt++;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cur_epoch = 2'd0;
        #1;
        total_cnt++;
        if (count !== 2'd0 || out_valid !== 1'b0 || out_instr !== NOP ||
            out_epoch !== 2'd0 || squash_cnt !== 2'd1 || in_ready !== 1'b1)
            $display("FAIL flush_empty: cnt=%0d valid=%b instr=%h ep=%0d sqc=%0d rdy=%b",
                     count, out_valid, out_instr, out_epoch, squash_cnt, in_ready);
        else pass_cnt++;
        push_one(32'h0A0A0A0A, 2'd0);
        total_cnt++;
        if (count !== 2'd1 || out_instr !== 32'h0A0A0A0A)
            $display("FAIL flush_after: cnt=%0d instr=%h want 1 0a0a0a0a", count, out_instr);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        push_one(32'hB0B0B0B0, 2'd0);
        total_cnt++;
        if (count !== 2'd2)
            $display("FAIL mid_prefill: cnt=%0d want 2", count);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_saturation();
        logic [1:0] exp_sq;
        cur_epoch = 2'd0;
        for (int k = 0; k < 5; k++) begin
            push_one(32'h50000000 + k, 2'd2);
            pop_one();
            exp_sq = (k + 1 > 3) ? 2'd3 : 2'(k + 1);
            total_cnt++;
            if (squash_cnt !== exp_sq)
                $display("FAIL sat[%0d]: sqc=%0d want %0d", k, squash_cnt, exp_sq);
            else pass_cnt++;
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        in_instr  = '0;
        in_epoch  = '0;
        cur_epoch = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #2;
        test_reset();
        #10 rst_n = 1'b1;
        step();
        test_fill_drain();
        test_squash();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: run exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
